// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and helpers for the multi-channel PWM block.
//   MODE_EDGE / MODE_CENTER : alignment encodings for center_mode
//   DIR_UP / DIR_DOWN       : period counter direction encodings
//   ch_width()              : width of a channel index for a given channel count
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    // A single channel still needs a 1-bit index port.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control and output bundle of the multi-channel PWM block.
//   enable        run the shared period counter; low = idle, outputs low
//   period        period value P, sampled at a period boundary
//   center_mode   0 = edge-aligned, 1 = center-aligned, sampled at a boundary
//   wr_en/wr_ch/wr_duty  duty write into a channel's shadow register
//   pwm_out       registered PWM outputs, one bit per channel
//   period_start  registered pulse in the first cycle of each period
// master = control/register side, slave = PWM generator.
interface pwm_multi_if
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned CH_W = ch_width(CHANNELS);

    logic                enable;
    logic [WIDTH-1:0]    period;
    logic                center_mode;
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [WIDTH-1:0]    wr_duty;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;

    modport master (
        output enable, period, center_mode, wr_en, wr_ch, wr_duty,
        input  pwm_out, period_start
    );

    modport slave (
        input  enable, period, center_mode, wr_en, wr_ch, wr_duty,
        output pwm_out, period_start
    );

endinterface

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: shared period counter for all PWM channels.
// Owns the counter, its direction, and the active period/mode, which are only
// reloaded at a period boundary.
//   clk, reset     clock, asynchronous active-high reset
//   enable         low holds the counter at 0 counting up (every cycle a boundary)
//   period         period value P, loaded at a boundary
//   center_mode    alignment mode, loaded at a boundary
//   count          current counter value
//   boundary       counter is 0 and counting up, or enable is low
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    input  logic             center_mode,
    output logic [WIDTH-1:0] count,
    output logic             boundary
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] act_p_q, act_p_d;
    logic             dir_q, dir_d;
    logic             act_mode_q, act_mode_d;

    always_comb begin
        boundary   = !enable || (count_q == '0 && dir_q == DIR_UP);
        // The step out of a boundary cycle already uses the newly sampled P/mode.
        act_p_d    = boundary ? period : act_p_q;
        act_mode_d = boundary ? center_mode : act_mode_q;
        count_d    = count_q;
        dir_d      = dir_q;

        if (!enable) begin
            count_d = '0;
            dir_d   = DIR_UP;
        end else if (act_mode_d == MODE_EDGE) begin
            dir_d   = DIR_UP;
            count_d = (count_q >= act_p_d) ? '0 : count_q + ONE;
        end else if (dir_q == DIR_UP) begin
            if (count_q < act_p_d) begin
                count_d = count_q + ONE;
            end else if (act_p_d > ONE) begin
                // Peak reached: P is visited once, descent starts at P-1.
                count_d = act_p_d - ONE;
                dir_d   = DIR_DOWN;
            end else begin
                // P<=1 has no descending leg.
                count_d = '0;
            end
        end else begin
            if (count_q <= ONE) begin
                count_d = '0;
                dir_d   = DIR_UP;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            dir_q      <= DIR_UP;
            act_p_q    <= '0;
            act_mode_q <= MODE_EDGE;
        end else begin
            count_q    <= count_d;
            dir_q      <= dir_d;
            act_p_q    <= act_p_d;
            act_mode_q <= act_mode_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with a shared period counter.
// Each channel has a shadow duty (written any time) and an active duty that is
// refreshed from the shadow only at a period boundary, so a period never glitches.
//   clk, reset   clock, asynchronous active-high reset
//   bus          pwm_multi_if slave: enable, period, center_mode, duty writes in;
//                pwm_out and period_start out (both registered)
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input logic          clk,
    input logic          reset,
    pwm_multi_if.slave   bus
);

    localparam int unsigned CH_W = ch_width(CHANNELS);

    logic [WIDTH-1:0]    count;
    logic                boundary;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [CHANNELS-1:0] cmp;
    logic [CHANNELS-1:0] pwm_q;
    logic                start_q;

    pwm_period_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .enable      (bus.enable),
        .period      (bus.period),
        .center_mode (bus.center_mode),
        .count       (count),
        .boundary    (boundary)
    );

    // A write in the boundary cycle lands in the shadow and is picked up as the
    // active duty in the same cycle, so it governs the period that starts here.
    // Out-of-range channel indices never match and are dropped.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (bus.wr_en && bus.wr_ch == CH_W'(i)) begin
                shadow_d[i] = bus.wr_duty;
            end
            active_d[i] = boundary ? shadow_d[i] : active_q[i];
            cmp[i]      = count < active_d[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pwm_q   <= '0;
            start_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            pwm_q   <= bus.enable ? cmp : '0;
            start_q <= bus.enable && boundary;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = start_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed scenarios plus randomized stimulus for pwm_multi,
// checked against a period-position reference model; a 3-channel instance
// covers out-of-range channel writes.
module tb_pwm_multi;
    import pwm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pwm_multi_if #(.WIDTH(8), .CHANNELS(4)) bus ();
    pwm_multi_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

    pwm_multi #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pwm_multi #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: position within the period, period length from P/mode.
    int         m_pos, m_p, m_cnt;
    bit         m_mode, m_bnd;
    int         m_sh[4];
    int         m_act[4];
    logic [3:0] e_pwm;
    logic       e_ps;

    function automatic int m_len();
        if (m_p == 0) return 1;
        return m_mode ? 2 * m_p : m_p + 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pos = 0; m_p = 0; m_mode = 0;
            for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_act[i] = 0; end
            e_pwm = '0; e_ps = 1'b0;
        end else begin
            m_bnd = !bus.enable || m_pos == 0;
            if (bus.wr_en) m_sh[bus.wr_ch] = int'(bus.wr_duty);
            if (m_bnd) begin
                m_p = int'(bus.period);
                m_mode = bus.center_mode;
                for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
            end
            m_cnt = (m_mode && m_pos > m_p) ? 2 * m_p - m_pos : m_pos;
            for (int i = 0; i < 4; i++) e_pwm[i] = bus.enable && (m_cnt < m_act[i]);
            e_ps  = bus.enable && m_bnd;
            m_pos = bus.enable ? (m_pos + 1) % m_len() : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check_eq("model_pwm_out", int'(bus.pwm_out), int'(e_pwm));
            check_eq("model_period_start", int'(bus.period_start), int'(e_ps));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int duty);
        bus.wr_en = 1'b1;
        bus.wr_ch = 2'(ch);
        bus.wr_duty = 8'(duty);
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_ps();
        bit seen = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (bus.period_start) begin seen = 1; break; end
        end
        check_eq("period_start_seen", int'(seen), 1);
    endtask

    // Counts outputs over len cycles starting at the current negedge.
    // act: 1 = duty write (a=ch, b=duty), 2 = set period a, 3 = toggle mode.
    task automatic measure(input int len, input int act, input int step, input int a,
                           input int b, output int hi[4], output int nps);
        for (int c = 0; c < 4; c++) hi[c] = 0;
        nps = 0;
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            for (int c = 0; c < 4; c++) if (bus.pwm_out[c]) hi[c]++;
            if (bus.period_start) nps++;
            if (k == step) begin
                case (act)
                    1: begin bus.wr_en = 1'b1; bus.wr_ch = 2'(a); bus.wr_duty = 8'(b); end
                    2: bus.period = 8'(a);
                    3: bus.center_mode = ~bus.center_mode;
                    default: ;
                endcase
            end
            if (k == step + 1 && act == 1) bus.wr_en = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi[4];
        int nps;
        int h3[3];
        int n3;
        bit seen3;

        bus.enable = 0; bus.period = 0; bus.center_mode = 0;
        bus.wr_en = 0; bus.wr_ch = 0; bus.wr_duty = 0;
        bus3.enable = 0; bus3.period = 0; bus3.center_mode = 0;
        bus3.wr_en = 0; bus3.wr_ch = 0; bus3.wr_duty = 0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_pwm_out", int'(bus.pwm_out), 0);
        check_eq("reset_period_start", int'(bus.period_start), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        chk_en = 1;
        cyc();

        // Edge mode, P=9, duties 0/3/9/10.
        bus.period = 9; bus.center_mode = 0;
        wr(0, 0); wr(1, 3); wr(2, 9); wr(3, 10);
        bus.enable = 1;
        @(negedge clk);
        check_eq("enable_ps_not_yet", int'(bus.period_start), 0);
        @(negedge clk);
        check_eq("enable_first_ps", int'(bus.period_start), 1);
        measure(10, 0, -1, 0, 0, hi, nps);
        check_eq("edge_ch0_high", hi[0], 0);
        check_eq("edge_ch1_high", hi[1], 3);
        check_eq("edge_ch2_high", hi[2], 9);
        check_eq("edge_ch3_high", hi[3], 10);
        check_eq("edge_ps_count", nps, 1);
        @(negedge clk);
        check_eq("edge_period_len", int'(bus.period_start), 1);

        // Center mode, P=5, ch0 duty 2.
        bus.center_mode = 1; bus.period = 5;
        cyc();
        wr(0, 2);
        wait_ps(); wait_ps();
        measure(10, 0, -1, 0, 0, hi, nps);
        check_eq("center_ch0_high", hi[0], 3);
        check_eq("center_ch1_high", hi[1], 5);
        check_eq("center_ps_count", nps, 1);
        @(negedge clk);
        check_eq("center_period_len", int'(bus.period_start), 1);

        // Mid-period duty write at counter=4, then a write in the boundary cycle.
        bus.period = 9; bus.center_mode = 0;
        cyc();
        wr(1, 3);
        wait_ps(); wait_ps();
        measure(10, 1, 3, 1, 7, hi, nps);
        check_eq("midwr_cur_period", hi[1], 3);
        @(negedge clk);
        measure(10, 0, -1, 0, 0, hi, nps);
        check_eq("midwr_next_period", hi[1], 7);
        bus.wr_en = 1; bus.wr_ch = 1; bus.wr_duty = 5;
        @(negedge clk);
        bus.wr_en = 0;
        measure(10, 0, -1, 0, 0, hi, nps);
        check_eq("bndwr_same_period", hi[1], 5);
        check_eq("bndwr_ps_count", nps, 1);

        // Period change 9->4 at counter=6, then mode toggle mid-period.
        @(negedge clk);
        measure(10, 2, 5, 4, 0, hi, nps);
        check_eq("pchg_old_ps", nps, 1);
        @(negedge clk);
        check_eq("pchg_old_len", int'(bus.period_start), 1);
        measure(5, 0, -1, 0, 0, hi, nps);
        @(negedge clk);
        check_eq("pchg_new_len", int'(bus.period_start), 1);
        measure(5, 3, 2, 0, 0, hi, nps);
        check_eq("mchg_old_ps", nps, 1);
        @(negedge clk);
        check_eq("mchg_old_len", int'(bus.period_start), 1);
        measure(8, 0, -1, 0, 0, hi, nps);
        check_eq("mchg_new_ps", nps, 1);
        @(negedge clk);
        check_eq("mchg_new_len", int'(bus.period_start), 1);

        // Asynchronous reset at counter=5 with ch3 high.
        bus.center_mode = 0; bus.period = 9;
        cyc();
        wait_ps(); wait_ps();
        repeat (4) @(negedge clk);
        check_eq("rst_pre_ch3", int'(bus.pwm_out[3]), 1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_pwm_out", int'(bus.pwm_out), 0);
        check_eq("async_rst_ps", int'(bus.period_start), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        wait_ps();
        measure(10, 0, -1, 0, 0, hi, nps);
        for (int c = 0; c < 4; c++) check_eq($sformatf("post_rst_ch%0d", c), hi[c], 0);
        check_eq("post_rst_ps", nps, 1);

        // Enable gating.
        cyc();
        wr(2, 4);
        bus.enable = 0;
        repeat (20) cyc();
        check_eq("disabled_pwm_out", int'(bus.pwm_out), 0);
        check_eq("disabled_ps", int'(bus.period_start), 0);
        bus.enable = 1;
        @(negedge clk);
        check_eq("reenable_ps_not_yet", int'(bus.period_start), 0);
        @(negedge clk);
        check_eq("reenable_ps", int'(bus.period_start), 1);

        // P=0 with duty 1: constant high, period_start every cycle.
        bus.period = 0;
        cyc();
        wr(0, 1);
        wait_ps(); wait_ps();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("p0_ps", int'(bus.period_start), 1);
            check_eq("p0_ch0", int'(bus.pwm_out[0]), 1);
        end

        // P=255 with duty 255: 255 high, 1 low.
        bus.period = 255;
        cyc();
        wr(0, 255);
        wait_ps(); wait_ps();
        measure(256, 0, -1, 0, 0, hi, nps);
        check_eq("p255_ch0_high", hi[0], 255);
        check_eq("p255_ps_count", nps, 1);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int it = 0; it < 3000; it++) begin
            cyc();
            bus.enable = ($urandom_range(15) != 0);
            if ($urandom_range(39) == 0)
                bus.period = ($urandom_range(1) != 0) ? 8'($urandom_range(7)) : 8'($urandom);
            if ($urandom_range(59) == 0) bus.center_mode = ~bus.center_mode;
            bus.wr_en = ($urandom_range(3) == 0);
            bus.wr_ch = 2'($urandom_range(3));
            bus.wr_duty = ($urandom_range(1) != 0) ? 8'($urandom_range(int'(bus.period) + 1))
                                                   : 8'($urandom);
            if (it == 1500) begin
                #2 reset = 1'b1;
                #3 reset = 1'b0;
            end
        end
        cyc();
        bus.wr_en = 0;

        // 3-channel build: a write to channel index 3 must change nothing.
        bus3.period = 9;
        for (int c = 0; c < 3; c++) begin
            bus3.wr_en = 1; bus3.wr_ch = 2'(c); bus3.wr_duty = 8'(2 * c + 2);
            cyc();
        end
        bus3.wr_ch = 3; bus3.wr_duty = 9;
        cyc();
        bus3.wr_en = 0;
        bus3.enable = 1;
        seen3 = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus3.period_start) begin seen3 = 1; break; end
        end
        check_eq("ch3_ps_seen", int'(seen3), 1);
        for (int c = 0; c < 3; c++) h3[c] = 0;
        n3 = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            for (int c = 0; c < 3; c++) if (bus3.pwm_out[c]) h3[c]++;
            if (bus3.period_start) n3++;
        end
        check_eq("oob_write_ch0", h3[0], 2);
        check_eq("oob_write_ch1", h3[1], 4);
        check_eq("oob_write_ch2", h3[2], 6);
        check_eq("oob_write_ps", n3, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
